// File: rtl/result_queue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : result_queue_arbiter_if
// Description : Search-unit request / result-queue write bundle for the
//               result queue arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_queue_arbiter_if #(
    parameter int NUM_REQ = 16,
    parameter int KEY_W   = 32
);
    logic                     stop;
    logic [NUM_REQ-1:0]       writeReq;
    logic [NUM_REQ*KEY_W-1:0] keyIn;
    logic                     Qfull;
    logic                     enableQ;
    logic [KEY_W-1:0]         dataToQ;
    logic [4:0]               writeQen;
    logic [NUM_REQ-1:0]       writeSucceeded;
    logic                     incrPC;
    logic [15:0]              stallCount;

    // Requester / queue side
    modport master (
        output stop, writeReq, keyIn, Qfull,
        input  enableQ, dataToQ, writeQen, writeSucceeded, incrPC, stallCount
    );

    // Arbiter side
    modport slave (
        input  stop, writeReq, keyIn, Qfull,
        output enableQ, dataToQ, writeQen, writeSucceeded, incrPC, stallCount
    );
endinterface
`default_nettype wire

// File: rtl/result_queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : result_queue_arbiter
// Description : Round-robin arbiter writing one search-unit key per cycle into
//               the found-key result queue. Optional macro ARB_STALL_CNT_EN
//               builds a saturating blocked-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module result_queue_arbiter #(
    parameter int NUM_REQ = 16,
    parameter int KEY_W   = 32
) (
    input  wire                          clk,
    input  wire                          rst,
    result_queue_arbiter_if.slave        bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] c_PTR_RST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_mask;
    logic               r_enq;
    logic [KEY_W-1:0]   r_data;
    logic [4:0]         r_qen;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_incr;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic               w_grant;
    logic [NUM_REQ-1:0] w_onehot;

    assign w_elig = bus.writeReq & ~r_mask;

    // Scan upward from ptr+1; offset NUM_REQ wraps back to ptr itself.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [IDX_W-1:0] idx;
            idx = r_ptr + IDX_W'(k);
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_grant  = !bus.stop && !bus.Qfull && w_found;
    assign w_onehot = NUM_REQ'(1) << w_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= c_PTR_RST;
            r_mask <= '0;
            r_enq  <= 1'b0;
            r_data <= '0;
            r_qen  <= '0;
            r_ack  <= '0;
            r_incr <= 1'b0;
        end else begin
            if (bus.stop) begin
                r_ptr <= c_PTR_RST;
            end else if (w_grant) begin
                r_ptr <= w_win;
            end
            if (w_grant) begin
                r_mask <= w_onehot;
                r_enq  <= 1'b1;
                r_data <= bus.keyIn[w_win*KEY_W +: KEY_W];
                r_qen  <= {1'b1, 4'(w_win)};
                r_ack  <= w_onehot;
                r_incr <= 1'b1;
            end else begin
                r_mask <= '0;
                r_enq  <= 1'b0;
                r_qen  <= '0;
                r_ack  <= '0;
                r_incr <= 1'b0;
            end
        end
    end

    assign bus.enableQ        = r_enq;
    assign bus.dataToQ        = r_data;
    assign bus.writeQen       = r_qen;
    assign bus.writeSucceeded = r_ack;
    assign bus.incrPC         = r_incr;

`ifdef ARB_STALL_CNT_EN
    logic [15:0] r_stall;

    // Counts cycles a request is blocked purely by queue back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
        end else if ((|bus.writeReq) && !bus.stop && bus.Qfull && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign bus.stallCount = r_stall;
`else
    assign bus.stallCount = 16'h0000;
`endif
endmodule
`default_nettype wire

// File: tb/tb_result_queue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_queue_arbiter
// Description : Directed self-checking bench for result_queue_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_queue_arbiter;
    localparam int NUM_REQ = 16;
    localparam int KEY_W   = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   pulses;

    result_queue_arbiter_if #(.NUM_REQ(NUM_REQ), .KEY_W(KEY_W)) bus ();

    result_queue_arbiter #(.NUM_REQ(NUM_REQ), .KEY_W(KEY_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] key_of(input int i);
        if (i == 3) return 32'hF0F0FF00;
        return {16'hA000 + 16'(i), 16'h5000 + 16'(i)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_enq"}, 32'(bus.enableQ), 32'h0);
        check({tag, "_qen"}, 32'(bus.writeQen), 32'h0);
        check({tag, "_ack"}, 32'(bus.writeSucceeded), 32'h0);
        check({tag, "_incr"}, 32'(bus.incrPC), 32'h0);
    endtask

    task automatic check_grant(input string tag, input int idx);
        check({tag, "_enq"}, 32'(bus.enableQ), 32'h1);
        check({tag, "_qen"}, 32'(bus.writeQen), 32'(5'h10 | 5'(idx)));
        check({tag, "_ack"}, 32'(bus.writeSucceeded), 32'(16'(1) << idx));
        check({tag, "_incr"}, 32'(bus.incrPC), 32'h1);
        check({tag, "_data"}, bus.dataToQ, key_of(idx));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst          = 1'b1;
        bus.stop     = 1'b0;
        bus.writeReq = '0;
        bus.Qfull    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bus.keyIn[i*KEY_W +: KEY_W] = key_of(i);
        step();
        step();
        check_idle("reset");
        check("reset_data", bus.dataToQ, 32'h0);
        check("reset_stall", 32'(bus.stallCount), 32'h0);
        rst = 1'b0;

        // Single request from unit 3
        bus.writeReq = 16'h0008;
        step();
        check_grant("single", 3);
        check("single_qen_lit", 32'(bus.writeQen), 32'h13);
        step();
        check_idle("single_masked");
        check("single_hold", bus.dataToQ, 32'hF0F0FF00);
        bus.writeReq = '0;
        step();

        // Fairness: all requesting, mask forces rotation 0..15,0
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.writeReq = 16'hFFFF;
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            step();
            check_grant($sformatf("fair%0d", i), i % NUM_REQ);
            if (i < 16 && bus.incrPC) pulses++;
        end
        check("fair_pulses", 32'(pulses), 32'd16);
        bus.writeReq = '0;
        step();
        step();

        // Back-pressure with requests 0 and 5
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.writeReq = 16'h0021;
        bus.Qfull    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("bp_block%0d", i), 32'(bus.enableQ), 32'h0);
        end
        bus.Qfull = 1'b0;
        step();
        check_grant("bp_first", 0);
        step();
        check_grant("bp_second", 5);
        bus.writeReq = '0;
        step();
        check_idle("bp_done");
`ifdef ARB_STALL_CNT_EN
        check("bp_stall", 32'(bus.stallCount), 32'd4);
`else
        check("bp_stall", 32'(bus.stallCount), 32'd0);
`endif

        // Stop: after grant to 7, priority restarts at 0
        bus.writeReq = 16'h0080;
        step();
        check_grant("stop_pre", 7);
        bus.stop     = 1'b1;
        bus.writeReq = 16'h0081;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stop_block%0d", i), 32'(bus.enableQ), 32'h0);
        end
        bus.Qfull = 1'b1;
        step();
        check("stop_qfull_block", 32'(bus.enableQ), 32'h0);
        bus.Qfull = 1'b0;
        bus.stop  = 1'b0;
        step();
        check_grant("stop_rel0", 0);
        step();
        check_grant("stop_rel7", 7);
        bus.writeReq = '0;
        step();

        // Reset mid-stream
        bus.writeReq = 16'hFFFF;
        step();
        check_grant("mid_pre", 8);
        step();
        check_grant("mid_pre2", 9);
        rst = 1'b1;
        step();
        check_idle("mid_rst");
        check("mid_rst_data", bus.dataToQ, 32'h0);
        rst = 1'b0;
        bus.writeReq = 16'h0C00;
        step();
        check_grant("mid_restart", 10);
        bus.writeReq = '0;
        step();

`ifdef ARB_STALL_CNT_EN
        // Saturation of the blocked-cycle counter
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.writeReq = 16'h0001;
        bus.Qfull    = 1'b1;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        check("sat_value", 32'(bus.stallCount), 32'hFFFF);
        for (int i = 0; i < 5; i++) step();
        check("sat_stable", 32'(bus.stallCount), 32'hFFFF);
        check("sat_noenq", 32'(bus.enableQ), 32'h0);
        bus.Qfull    = 1'b0;
        bus.writeReq = '0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/result_queue_arbiter.md
# result_queue_arbiter

Round-robin arbiter that shares the single found-key result queue between the accelerator's search units. Each search unit raises a write request with its candidate key; the arbiter grants at most one per cycle while the queue has space and writes the winner's key into the queue. It acknowledges the winner and pulses the performance-count increment. It sits between the level controllers' search units and the result queue/performance counter, and is quiesced by the accelerator control `stop`.

## Interface
- `NUM_REQ`, 16, number of search-unit requesters (power of two, 2..16)
- `KEY_W`, 32, key width ({upper 16, lower 16} as held in the key buffer)
- `clk` in 1, system clock, all logic on rising edge
- `rst` in 1, synchronous, active-high reset
- `stop` in 1, accelerator stop; blocks grants while high
- `writeReq` in NUM_REQ, per-search-unit write request, level-held until acknowledged
- `keyIn` in NUM_REQ*KEY_W, flattened keys; requester i uses bits [i*KEY_W +: KEY_W]
- `Qfull` in 1, queue almost-full: high when ≤1 free entry remains
- `enableQ` out 1, queue write strobe
- `dataToQ` out KEY_W, key written when `enableQ` is high
- `writeQen` out 5, {grant valid, granted index[3:0]}; index zero-extended when NUM_REQ<16
- `writeSucceeded` out NUM_REQ, one-hot acknowledge, one-cycle pulse
- `incrPC` out 1, performance-count increment, one pulse per accepted write
- `stallCount` out 16, blocked-cycle count (see Configuration)

## Operation
- Reset: all outputs 0; priority pointer `ptr` = NUM_REQ-1; mask register 0.
- Each edge, eligible = `writeReq` & ~mask. A grant occurs iff `stop`=0, `Qfull`=0, eligible≠0.
- Winner: first eligible index searching upward from `ptr`+1 modulo NUM_REQ (wrap-around). On grant, `ptr` ← winner.
- On grant (registered): `enableQ`=1, `dataToQ`=key of winner, `writeQen`={1,winner}, `writeSucceeded`=one-hot(winner), `incrPC`=1, mask ← one-hot(winner).
- No grant: `enableQ`, `writeQen`, `writeSucceeded`, `incrPC`, mask all ← 0. `dataToQ` holds its last value.
- Mask covers the one cycle in which the acknowledged requester still shows `writeReq`. Requesters must drop `writeReq` the cycle after seeing `writeSucceeded`.
- A requester not granted keeps `writeReq` high. No request is lost or reordered per requester.
- `stop`=1: no grants; `ptr` ← NUM_REQ-1 so the next search restarts priority at index 0. In-flight outputs from the previous edge complete normally.
- `Qfull` and `stop` together: `stop` governs (`ptr` reset).
- A single requester holding `writeReq` is granted at most every other cycle, because of the mask.

## Timing
- One-cycle latency: request sampled at edge N; `enableQ`/`writeSucceeded`/`incrPC` high in the cycle following edge N.
- Throughput: one write per cycle when different requesters alternate.
- `Qfull` is sampled at the same edge as the request. Because writes are registered, the queue must assert `Qfull` with one entry still free, so the in-flight write never overflows.
- `rst` mid-operation: next cycle all outputs 0, `ptr`=NUM_REQ-1, mask cleared; any pending grant is dropped and the requester re-requests.

## Configuration
- `ARB_STALL_CNT_EN` defined: 16-bit `stallCount` increments each cycle where `writeReq`≠0, `stop`=0 and `Qfull`=1. It saturates at 16'hFFFF and is cleared by `rst` only.
- Not defined: `stallCount` tied to 16'h0000 and no counter logic is built. All other behaviour is identical.

## Test plan
- Single request: `writeReq`=16'h0008, key3=32'hF0F0FF00 -> next cycle `enableQ`=1, `dataToQ`=32'hF0F0FF00, `writeQen`=5'h13, `writeSucceeded`=16'h0008, `incrPC`=1; one pulse only.
- Fairness: `writeReq`=16'hFFFF held after reset, each acknowledged requester re-raising two cycles later -> grants in order 0,1,2,…,15,0; exactly 16 `incrPC` pulses in 16 cycles.
- Back-pressure: requests 0 and 5 pending, `Qfull`=1 for 4 cycles -> no `enableQ` during those cycles; after `Qfull` drops, grant 0 and then 5 on consecutive cycles. With `ARB_STALL_CNT_EN`, `stallCount`=4.
- Stop: grant to 7, then `stop`=1 with `writeReq`=16'h0081 -> no grants while `stop` is high; after release, 0 is granted first, then 7.
- Reset mid-stream: `rst` asserted for one cycle during continuous grants -> the following cycle has all outputs 0; after reset, grants restart at the lowest pending index.
- Saturation (macro on): `Qfull`=1 with a pending request for 70000 cycles -> `stallCount`=16'hFFFF, stable.
